imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader upstream of the core's instruction memory.
- Receives a program image over a UART serial line (8N1), assembles big-endian 32-bit words, and writes them into instruction memory through a dedicated write port.
- Holds the core in reset until the image is complete, then releases it.
- Sits between the board RX pin and the instruction BRAM write port; the core reads the same BRAM via o_addr/odata.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4
- ADDR_W, 10, instruction memory word-address width
- DEPTH, 1024, instruction memory depth in words; maximum accepted word count

Ports:
- clk  input  1  system clock; all logic on rising edge
- rstn  input  1  synchronous active-low reset
- rxd  input  1  asynchronous UART receive line, idle high
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  ADDR_W  instruction memory write word-address
- imem_wdata  output  32  instruction word to write
- core_rstn  output  1  active-low reset to core; low until load completes
- load_done  output  1  high once the image has been fully written
- err  output  1  sticky error flag (framing error or oversize count)

Behaviour:
- Reset values (rstn low at clk edge): imem_we=0, imem_addr=0, imem_wdata=0, core_rstn=0, load_done=0, err=0. FSM goes to S_LEN; byte and word counters cleared; UART RX goes idle. Reset mid-load aborts the load and forces the core back into reset.
- rxd input: passes through a 2-flop synchronizer before any use.
- UART RX:
  - Start is a synced high->low transition while idle.
  - Sampling points: start bit re-checked at CLKS_PER_BIT/2; if high, treat as a glitch and return to idle. Data bits are sampled at each subsequent CLKS_PER_BIT, LSB first, then the stop bit.
  - Stop bit = 1: emit byte_valid for one cycle with byte_data.
  - Stop bit = 0: framing error; byte dropped, err set.
- Word assembly: big-endian. The first byte of each group of 4 lands in [31:24], the last in [7:0]. A 2-bit byte counter wraps after the 4th byte.
- FSM states:
  - S_LEN: collects 4 bytes into word_count N.
    - N=0: go to S_DONE.
    - N>DEPTH: set err, go to S_ERR.
    - Otherwise: go to S_DATA with word index = 0.
  - S_DATA: on the 4th byte of each word, in the following cycle: imem_we=1 for exactly one cycle, imem_addr = word index, imem_wdata = assembled word. Then the index increments. After writing index N-1, go to S_DONE.
  - S_DONE: load_done=1 in the first cycle of S_DONE. core_rstn=1 one cycle later and stays high. All further rxd bytes are ignored; no writes.
  - S_ERR: core_rstn stays 0, load_done stays 0, no writes. Leaves only on rstn.
- A framing error in S_LEN or S_DATA also forces S_ERR.
- Latency: imem_we asserts exactly 1 cycle after byte_valid of the 4th byte.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Write address wraps naturally only at DEPTH=2^ADDR_W; an oversize N is rejected before any write, so no wrap occurs in practice.
- Simultaneous events: byte_valid in the same cycle as the FSM transition to S_DONE cannot occur (a byte takes ≥10 bit times). rstn has priority over everything.

Decomposition:
- Shared package:
  - FSM state encoding localparams S_LEN, S_DATA, S_DONE, S_ERR
  - Default CLKS_PER_BIT constant, shared with a future UART TX block
- Sub-module uart_rx:
  - Ports: clk, rstn, rxd (already synchronized), byte_valid, byte_data[7:0], frame_err
  - Parameter: CLKS_PER_BIT
- imem_loader instantiates uart_rx and holds the synchronizer, word assembler, counters and FSM.

Test Plan (CLKS_PER_BIT=8 in simulation):
- N=2 image, bytes 00 00 00 02 DE AD BE EF 12 34 56 78 -> imem_we pulses twice: (addr 0, DEADBEEF) then (addr 1, 12345678). load_done rises 1 cycle after 2nd write; core_rstn rises the following cycle.
- N=0 (00 00 00 00) -> no imem_we; load_done=1 and core_rstn=1 on consecutive cycles after the 4th byte.
- N=1025 (00 00 04 01) -> err=1, no writes, core_rstn stays 0. Extra bytes ignored until rstn.
- Byte with stop bit forced 0 during S_DATA -> err=1, word not written, FSM in S_ERR, core_rstn=0.
- 1-clock low glitch on rxd while idle -> no byte_valid, no state change.
- rstn pulsed low after 1 of 3 words written -> all outputs return to reset values. A fresh N=1 image (00 00 00 01 CA FE BA BE) then writes addr 0 = CAFEBABE and releases the core.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the boot-time instruction
//               memory loader and its UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // 100 MHz system clock / 115200 baud. A future UART TX block reuses it.
  localparam int c_CLKS_PER_BIT = 868;

  // Loader control states.
  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } load_state_t;

  // UART receiver states.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Expects an already synchronized rxd.
//               Emits a one-cycle byte_valid per good frame and a one-cycle
//               frame_err when the stop bit samples low.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int                c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t          r_state;
  rx_state_t          w_next;
  logic               w_tick;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_prev;
  logic               r_valid;
  logic               r_ferr;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= RX_IDLE;
    else       r_state <= w_next;
  end

  // Next state; w_tick marks the sampling point inside the current bit.
  always_comb begin
    w_next = r_state;
    w_tick = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (r_prev && !rxd) w_next = RX_START;
      end
      RX_START: begin
        w_tick = (r_cnt == c_HALF);
        // A start bit that is high again at mid-bit was a glitch.
        if (w_tick) w_next = rxd ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        w_tick = (r_cnt == c_FULL);
        if (w_tick && (r_bit_idx == 3'd7)) w_next = RX_STOP;
      end
      RX_STOP: begin
        w_tick = (r_cnt == c_FULL);
        if (w_tick) w_next = RX_IDLE;
      end
      default: w_next = RX_IDLE;
    endcase
  end

  // Bit timer, LSB-first shift register and result strobes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_prev    <= 1'b1;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_prev  <= rxd;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if ((r_state == RX_IDLE) || w_tick) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;
      if (r_state == RX_START) r_bit_idx <= '0;
      if ((r_state == RX_DATA) && w_tick) begin
        r_shift   <= {rxd, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if ((r_state == RX_STOP) && w_tick) begin
        r_valid <= rxd;
        r_ferr  <= !rxd;
      end
    end
  end

  assign byte_valid = r_valid;
  assign byte_data  = r_shift;
  assign frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot loader. Receives a length-prefixed big-endian program
//               image over UART, writes it to instruction memory and then
//               releases the core from reset.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rstn,
  output logic              load_done,
  output logic              err
);

  logic              r_rxd_meta;
  logic              r_rxd_sync;
  logic              w_byte_valid;
  logic [7:0]        w_byte_data;
  logic              w_frame_err;

  load_state_t       r_state;
  load_state_t       w_next;
  logic              w_accept;
  logic              w_word_done;
  logic              w_write;
  logic [31:0]       w_word;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_word;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_last_idx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_load_done;
  logic              r_core_rstn;
  logic              r_err;

  // Two-flop synchronizer for the asynchronous RX pin (idles high).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk        (clk),
    .rstn       (rstn),
    .rxd        (r_rxd_sync),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .frame_err  (w_frame_err)
  );

  // Bytes only matter while the length or the image is being collected.
  assign w_accept    = w_byte_valid && ((r_state == S_LEN) || (r_state == S_DATA));
  assign w_word      = {r_word, w_byte_data};
  assign w_word_done = w_accept && (r_byte_cnt == 2'd3);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_LEN;
    else       r_state <= w_next;
  end

  // Next state and write request.
  always_comb begin
    w_next  = r_state;
    w_write = 1'b0;
    case (r_state)
      S_LEN: begin
        if (w_frame_err) begin
          w_next = S_ERR;
        end else if (w_word_done) begin
          if (w_word == 32'd0)               w_next = S_DONE;
          else if (w_word > 32'(DEPTH))      w_next = S_ERR;
          else                               w_next = S_DATA;
        end
      end
      S_DATA: begin
        w_write = w_word_done;
        if (w_frame_err) begin
          w_next = S_ERR;
        end else if (r_we && (r_addr == r_last_idx)) begin
          // Final word is on the write port this cycle.
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  // Word assembly, write port registers and status flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_byte_cnt  <= '0;
      r_word      <= '0;
      r_idx       <= '0;
      r_last_idx  <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_load_done <= 1'b0;
      r_core_rstn <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_we <= w_write;
      if (w_accept) begin
        r_word     <= w_word[23:0];
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if ((r_state == S_LEN) && w_word_done) begin
        r_idx      <= '0;
        r_last_idx <= ADDR_W'(w_word - 32'd1);
      end
      if (w_write) begin
        r_addr  <= r_idx;
        r_wdata <= w_word;
        r_idx   <= r_idx + 1'b1;
      end
      if (w_next == S_DONE) r_load_done <= 1'b1;
      // Core leaves reset the cycle after load_done is seen.
      r_core_rstn <= r_load_done;
      if (w_next == S_ERR) r_err <= 1'b1;
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign load_done  = r_load_done;
  assign core_rstn  = r_core_rstn;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader with a transaction-level
//               model of expected memory writes and release behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int CPB   = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          rxd  = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rstn;
  logic          load_done;
  logic          err;

  imem_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rxd        (rxd),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rstn  (core_rstn),
    .load_done  (load_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           cur;
  int            rel_mode = 0;   // 0: core held in reset, 1: timed release, 2: free
  int            err_mode = 0;   // 0: err must be low, 1: don't care, 2: must be high
  int            done_cyc = -1;
  int            cyc      = 0;
  int            n_writes = 0;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_data = '0;
  logic          prev_ld   = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      last_addr = '0;
      last_data = '0;
      done_cyc  = -1;
      prev_ld   = 1'b0;
    end else begin
      if (imem_we) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_addr, imem_wdata);
        end else begin
          cur = exp_q.pop_front();
          check("wr_addr", 32'(imem_addr), 32'(cur.addr));
          check("wr_data", imem_wdata, cur.data);
          last_addr = cur.addr;
          last_data = cur.data;
          if ((exp_q.size() == 0) && (rel_mode == 1)) done_cyc = cyc + 1;
        end
      end else begin
        check("hold_addr", 32'(imem_addr), 32'(last_addr));
        check("hold_data", imem_wdata, last_data);
      end
      if (rel_mode == 0) begin
        check("load_done_held", 32'(load_done), 32'd0);
        check("core_rstn_held", 32'(core_rstn), 32'd0);
      end else if (rel_mode == 1) begin
        check("load_done_timing", 32'(load_done), 32'(done_cyc >= 0 && cyc >= done_cyc));
        check("core_rstn_timing", 32'(core_rstn), 32'(done_cyc >= 0 && cyc > done_cyc));
      end
      // The core is released exactly one cycle after load_done, both sticky.
      check("core_rstn_follows", 32'(core_rstn), 32'(prev_ld));
      prev_ld = load_done;
      if (err_mode == 0)      check("err_low", 32'(err), 32'd0);
      else if (err_mode == 2) check("err_sticky", 32'(err), 32'd1);
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic expect_write(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    rxd  = 1'b1;
    exp_q.delete();
    rel_mode = 0;
    err_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},        32'(imem_we), 32'd0);
    check({tag, "_addr"},      32'(imem_addr), 32'd0);
    check({tag, "_wdata"},     imem_wdata, 32'd0);
    check({tag, "_core_rstn"}, 32'(core_rstn), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"},       32'(err), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (load_done) break;
      @(posedge clk);
      #1;
    end
    check({tag, "_load_done"}, 32'(load_done), 32'd1);
  endtask

  task automatic wait_queue(input string tag, input int left);
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == left) break;
      @(posedge clk);
      #1;
    end
    check({tag, "_pending"}, 32'(exp_q.size()), 32'(left));
  endtask

  int base;

  initial begin
    // Reset values.
    reset_dut();
    check_reset_values("rst");

    // One-clock glitch while idle, then an N=2 image on the same session.
    rxd = 1'b0;
    @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (4 * CPB) @(posedge clk);
    #1;
    check("glitch_no_write", 32'(n_writes), 32'd0);
    check("glitch_load_done", 32'(load_done), 32'd0);
    base     = n_writes;
    rel_mode = 1;
    expect_write(0, 32'hDEADBEEF);
    expect_write(1, 32'h12345678);
    send_word(32'd2);
    send_word(32'hDEADBEEF);
    send_word(32'h12345678);
    wait_done("n2", 50);
    repeat (2) @(posedge clk);
    #1;
    check("n2_writes", 32'(n_writes - base), 32'd2);
    check("n2_core_rstn", 32'(core_rstn), 32'd1);
    check("n2_last_addr", 32'(imem_addr), 32'd1);
    check("n2_last_data", imem_wdata, 32'h12345678);
    // Bytes after completion are ignored.
    send_word(32'h55667788);
    check("n2_ignored", 32'(n_writes - base), 32'd2);

    // N=0: no writes, immediate release.
    reset_dut();
    rel_mode = 2;
    base     = n_writes;
    send_word(32'd0);
    wait_done("n0", 20);
    repeat (2) @(posedge clk);
    #1;
    check("n0_core_rstn", 32'(core_rstn), 32'd1);
    check("n0_writes", 32'(n_writes - base), 32'd0);

    // N=1025: oversize, error, nothing written, core held.
    reset_dut();
    base     = n_writes;
    err_mode = 1;
    send_word(32'h00000401);
    repeat (4) @(posedge clk);
    #1;
    check("over_err", 32'(err), 32'd1);
    err_mode = 2;
    send_word(32'd1);
    send_word(32'hAABBCCDD);
    check("over_writes", 32'(n_writes - base), 32'd0);
    check("over_core_rstn", 32'(core_rstn), 32'd0);

    // Framing error inside the image.
    reset_dut();
    base = n_writes;
    expect_write(0, 32'h11223344);
    send_word(32'd2);
    send_word(32'h11223344);
    wait_queue("ferr", 0);
    err_mode = 1;
    send_byte(8'h55, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("ferr_err", 32'(err), 32'd1);
    err_mode = 2;
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    send_word(32'h99AABBCC);
    check("ferr_writes", 32'(n_writes - base), 32'd1);
    check("ferr_core_rstn", 32'(core_rstn), 32'd0);

    // Reset after one of three words, then a fresh N=1 image.
    reset_dut();
    rel_mode = 1;
    expect_write(0, 32'hA5A5A5A5);
    expect_write(1, 32'h5A5A5A5A);
    expect_write(2, 32'h0F0F0F0F);
    send_word(32'd3);
    send_word(32'hA5A5A5A5);
    wait_queue("mid", 2);
    reset_dut();
    check_reset_values("mid_rst");
    rel_mode = 1;
    base     = n_writes;
    expect_write(0, 32'hCAFEBABE);
    send_word(32'd1);
    send_word(32'hCAFEBABE);
    wait_done("fresh", 50);
    repeat (2) @(posedge clk);
    #1;
    check("fresh_writes", 32'(n_writes - base), 32'd1);
    check("fresh_core_rstn", 32'(core_rstn), 32'd1);
    check("fresh_data", imem_wdata, 32'hCAFEBABE);

    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
